// File: rtl/vsi_mod_ctrl.sv
// vsi_mod_ctrl: three-phase sine duty generator and start/ramp/run/stop/fault sequencer for the VSI PWM stage. Optional macro VSI_THIRD_HARM_EN.
// Latency: d1..d3 load 4 clk after the internal tick pulse (5 clk with VSI_THIRD_HARM_EN defined).
// Backpressure: none. One duty set per PWM period. fault forces ce=0 and D_MID duties on the next clk edge.
module vsi_mod_ctrl #(
    parameter int D_MAX     = 400,
    parameter int D_MID     = 200,
    parameter int RAMP_STEP = 16,
    parameter int PH_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwm_tick,
    input  logic            enable,
    input  logic            fault,
    input  logic            fault_clr,
    input  logic [PH_W-1:0] freq_word,
    input  logic [9:0]      amp_target,
    output logic [9:0]      d1,
    output logic [9:0]      d2,
    output logic [9:0]      d3,
    output logic            ce,
    output logic            running,
    output logic            faulted
);
    typedef enum logic [2:0] {S_IDLE, S_RAMP, S_RUN, S_STOP, S_FAULT} state_t;

    localparam logic [9:0]        STEP10 = 10'(RAMP_STEP);
    localparam logic [9:0]        MID10  = 10'(D_MID);
    localparam logic signed [11:0] MID12 = 12'(D_MID);
    localparam logic signed [11:0] MAX12 = 12'(D_MAX);

    // Quarter-wave of round(255*sin(2*pi*k/256)), k = 0..64.
    localparam logic [7:0] QSIN [0:64] = '{
        8'd0,   8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd37,  8'd44,  8'd50,  8'd56,
        8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,  8'd98,  8'd103, 8'd109, 8'd115,
        8'd120, 8'd126, 8'd131, 8'd136, 8'd142, 8'd147, 8'd152, 8'd157, 8'd162, 8'd167,
        8'd171, 8'd176, 8'd180, 8'd185, 8'd189, 8'd193, 8'd197, 8'd201, 8'd205, 8'd208,
        8'd212, 8'd215, 8'd219, 8'd222, 8'd225, 8'd228, 8'd231, 8'd233, 8'd236, 8'd238,
        8'd240, 8'd242, 8'd244, 8'd246, 8'd247, 8'd249, 8'd250, 8'd251, 8'd252, 8'd253,
        8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    state_t             state, st_nxt;
    logic [PH_W-1:0]    phase;
    logic [9:0]         amp_cur, amp_nxt;
    logic               tick_d, tick_p, proc, flush;
    logic               v1, v2, v3, fin_v;
    logic [7:0]         th_a, th_b, th_c;
    logic [9:0]         amp1, amp2;
    logic signed [8:0]  s_a, s_b, s_c;
    logic signed [9:0]  o_a, o_b, o_c;
    logic signed [10:0] fin_a, fin_b, fin_c;

    function automatic logic is_act(input state_t s);
        return (s == S_RAMP) || (s == S_RUN) || (s == S_STOP);
    endfunction

    // Mirror the quarter-wave: 65..127 fold back, upper half negates.
    function automatic logic signed [8:0] sin8(input logic [7:0] th);
        logic [6:0] i;
        logic [7:0] m;
        i = (th[6:0] > 7'd64) ? 7'(8'd128 - {1'b0, th[6:0]}) : th[6:0];
        m = QSIN[i];
        return th[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // (amp * sin * D_MID) >>> 18 in signed 32-bit; result is within +/-D_MID.
    function automatic logic signed [9:0] offs(input logic [9:0] a, input logic signed [8:0] s);
        return 10'((32'($signed({1'b0, a})) * 32'(s) * D_MID) >>> 18);
    endfunction

    function automatic logic [9:0] clamp_duty(input logic signed [10:0] off);
        logic signed [11:0] v;
        v = 12'(off) + MID12;
        if (v < 12'sd0) return 10'd0;
        if (v > MAX12)  return 10'(D_MAX);
        return v[9:0];
    endfunction

    // Registered rising-edge detect: tick_p is high for one clk after pwm_tick is first seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
            tick_p <= 1'b0;
        end else begin
            tick_d <= pwm_tick;
            tick_p <= pwm_tick & ~tick_d;
        end
    end

    // Next state; RAMP->RUN and STOP->IDLE are judged on a tick against the pre-step amplitude.
    always_comb begin
        st_nxt = state;
        case (state)
            S_IDLE:  if (enable) st_nxt = S_RAMP;
            S_RAMP:  if (!enable) st_nxt = S_STOP;
                     else if (tick_p && (amp_cur == amp_target)) st_nxt = S_RUN;
            S_RUN:   if (!enable) st_nxt = S_STOP;
            S_STOP:  if (enable) st_nxt = S_RAMP;
                     else if (tick_p && (amp_cur == 10'd0)) st_nxt = S_IDLE;
            S_FAULT: if (fault_clr && !enable) st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
        if (fault) st_nxt = S_FAULT;
    end

    // Amplitude slew for the state the tick is processed in (STOP heads to zero).
    always_comb begin
        amp_nxt = amp_cur;
        if (st_nxt == S_STOP)
            amp_nxt = (amp_cur > STEP10) ? amp_cur - STEP10 : 10'd0;
        else if (amp_cur < amp_target)
            amp_nxt = ((amp_target - amp_cur) > STEP10) ? amp_cur + STEP10 : amp_target;
        else if (amp_cur > amp_target)
            amp_nxt = ((amp_cur - amp_target) > STEP10) ? amp_cur - STEP10 : amp_target;
    end

    assign proc  = tick_p && is_act(state) && is_act(st_nxt);
    assign flush = (st_nxt == S_IDLE) || (st_nxt == S_FAULT);

    // Sequencer: state, phase/amplitude and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            phase   <= '0;
            amp_cur <= '0;
            ce      <= 1'b0;
            running <= 1'b0;
            faulted <= 1'b0;
        end else begin
            state   <= st_nxt;
            ce      <= is_act(st_nxt);
            running <= (st_nxt == S_RUN);
            faulted <= (st_nxt == S_FAULT);
            if (state == S_IDLE && st_nxt == S_RAMP) begin
                phase   <= '0;
                amp_cur <= '0;
            end else if (proc) begin
                phase   <= phase + freq_word;
                amp_cur <= amp_nxt;
            end
        end
    end

    // Duty datapath: angle register -> sine register -> scaled-offset register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            th_a <= '0; th_b <= '0; th_c <= '0; amp1 <= '0; amp2 <= '0;
            s_a  <= '0; s_b  <= '0; s_c  <= '0;
            o_a  <= '0; o_b  <= '0; o_c  <= '0;
        end else begin
            if (proc) begin
                th_a <= phase[PH_W-1 -: 8];
                th_b <= phase[PH_W-1 -: 8] - 8'd85;
                th_c <= phase[PH_W-1 -: 8] + 8'd85;
                amp1 <= amp_cur;
            end
            s_a  <= sin8(th_a);
            s_b  <= sin8(th_b);
            s_c  <= sin8(th_c);
            amp2 <= amp1;
            o_a  <= offs(amp2, s_a);
            o_b  <= offs(amp2, s_b);
            o_c  <= offs(amp2, s_c);
        end
    end

`ifdef VSI_THIRD_HARM_EN
    logic signed [9:0]  mx, mn;
    logic signed [10:0] cm;
    logic signed [10:0] o4_a, o4_b, o4_c;
    logic               v4;

    // Common-mode (max+min)/2 of the three offsets, floor division.
    always_comb begin
        mx = o_a;
        mn = o_a;
        if (o_b > mx) mx = o_b;
        if (o_c > mx) mx = o_c;
        if (o_b < mn) mn = o_b;
        if (o_c < mn) mn = o_c;
        cm = (11'(mx) + 11'(mn)) >>> 1;
    end

    // Extra stage removing the common mode from all three offsets.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            v4 <= 1'b0; o4_a <= '0; o4_b <= '0; o4_c <= '0;
        end else begin
            v4   <= v3;
            o4_a <= 11'(o_a) - cm;
            o4_b <= 11'(o_b) - cm;
            o4_c <= 11'(o_c) - cm;
        end
    end

    assign fin_v = v4;
    assign fin_a = o4_a;
    assign fin_b = o4_b;
    assign fin_c = o4_c;
`else
    assign fin_v = v3;
    assign fin_a = 11'(o_a);
    assign fin_b = 11'(o_b);
    assign fin_c = 11'(o_c);
`endif

    // Stage valids and duty output register; entering IDLE/FAULT drops in-flight results and parks at D_MID.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            d1 <= MID10; d2 <= MID10; d3 <= MID10;
        end else begin
            v1 <= proc;
            v2 <= v1;
            v3 <= v2;
            if (fin_v) begin
                d1 <= clamp_duty(fin_a);
                d2 <= clamp_duty(fin_b);
                d3 <= clamp_duty(fin_c);
            end
        end
    end

endmodule

// File: tb/tb_vsi_mod_ctrl.sv
// tb_vsi_mod_ctrl: self-checking bench for vsi_mod_ctrl with a duty scoreboard fed by a floating-point sine model.
// Latency: expected duties are compared a fixed number of clk after each PWM tick.
// Backpressure: none; stimulus is fully bench-paced.
module tb_vsi_mod_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_tick = 1'b0;
    logic        enable = 1'b0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic [15:0] freq_word = 16'd0;
    logic [9:0]  amp_target = 10'd0;
    logic [9:0]  d1, d2, d3;
    logic        ce, running, faulted;

    int n_vec = 0;
    int n_err = 0;

`ifdef VSI_THIRD_HARM_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic [29:0] exp_q [$];
    logic [15:0] m_phase = 16'd0;
    int          m_amp = 0;
    logic [29:0] m_last = {10'd200, 10'd200, 10'd200};

    vsi_mod_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_tick   (pwm_tick),
        .enable     (enable),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .freq_word  (freq_word),
        .amp_target (amp_target),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .ce         (ce),
        .running    (running),
        .faulted    (faulted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sin8(input int th);
        real v;
        v = 255.0 * $sin(2.0 * 3.14159265358979 * real'(th) / 256.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int step(input int a, input int t);
        if (a < t) return (a + 16 > t) ? t : a + 16;
        if (a > t) return (a - 16 < t) ? t : a - 16;
        return a;
    endfunction

    function automatic logic [29:0] model_duty(input logic [15:0] ph, input int amp);
        int th [3];
        int off [3];
        int d [3];
`ifdef VSI_THIRD_HARM_EN
        int mx, mn, cm;
`endif
        th[0] = int'(ph[15:8]);
        th[1] = (th[0] + 171) % 256;
        th[2] = (th[0] + 85) % 256;
        for (int i = 0; i < 3; i++)
            off[i] = $rtoi($floor(real'(amp * sin8(th[i]) * 200) / 262144.0));
`ifdef VSI_THIRD_HARM_EN
        mx = off[0]; mn = off[0];
        for (int i = 1; i < 3; i++) begin
            if (off[i] > mx) mx = off[i];
            if (off[i] < mn) mn = off[i];
        end
        cm = (mx + mn) >>> 1;
        for (int i = 0; i < 3; i++) off[i] = off[i] - cm;
`endif
        for (int i = 0; i < 3; i++) begin
            d[i] = 200 + off[i];
            if (d[i] < 0)   d[i] = 0;
            if (d[i] > 400) d[i] = 400;
        end
        return {10'(d[0]), 10'(d[1]), 10'(d[2])};
    endfunction

    // One PWM period. proc: the tick is expected to produce duties; dn: amplitude heads to zero;
    // drop_en: enable falls in the same cycle as the internal tick pulse.
    task automatic do_tick(input bit proc, input bit dn, input bit drop_en);
        logic [29:0] e;
        if (proc) begin
            exp_q.push_back(model_duty(m_phase, m_amp));
            m_phase = m_phase + freq_word;
            m_amp   = step(m_amp, dn ? 0 : int'(amp_target));
        end
        @(negedge clk) pwm_tick = 1'b1;
        @(negedge clk) begin
            pwm_tick = 1'b0;
            if (drop_en) enable = 1'b0;
        end
        repeat (LAT + 2) @(negedge clk);
        if (proc) begin
            e = exp_q.pop_front();
            chk("duty_a", 32'(d1), 32'(e[29:20]));
            chk("duty_b", 32'(d2), 32'(e[19:10]));
            chk("duty_c", 32'(d3), 32'(e[9:0]));
            m_last = e;
        end
    endtask

    // Tick with exact-latency check: d1 holds its old value until exactly LAT clk after the pulse.
    task automatic tick_lat();
        logic [29:0] e;
        e = model_duty(m_phase, m_amp);
        m_phase = m_phase + freq_word;
        m_amp   = step(m_amp, int'(amp_target));
        @(negedge clk) pwm_tick = 1'b1;
        @(negedge clk) pwm_tick = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) chk("lat_hold_a", 32'(d1), 32'(m_last[29:20]));
            else         chk("lat_upd_a", 32'(d1), 32'(e[29:20]));
        end
        chk("lat_upd_b", 32'(d2), 32'(e[19:10]));
        chk("lat_upd_c", 32'(d3), 32'(e[9:0]));
        m_last = e;
    endtask

    initial begin
        // Reset held 3 clk with enable high.
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d1", 32'(d1), 32'd200);
        chk("rst_d2", 32'(d2), 32'd200);
        chk("rst_d3", 32'(d3), 32'd200);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_faulted", 32'(faulted), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        enable = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ce", 32'(ce), 32'd0);

        // Start ramp to 512 at freq 0: RUN after 33 ticks.
        amp_target = 10'd512;
        freq_word  = 16'd0;
        enable     = 1'b1;
        m_phase    = 16'd0;
        m_amp      = 0;
        @(negedge clk);
        chk("ramp_ce", 32'(ce), 32'd1);
        for (int k = 1; k <= 33; k++) begin
            do_tick(1'b1, 1'b0, 1'b0);
            chk("ramp_running", 32'(running), 32'(k == 33));
        end

        // Slew in RUN up to full scale, then steady duties at phase 0.
        amp_target = 10'd1023;
        for (int k = 0; k < 33; k++) do_tick(1'b1, 1'b0, 1'b0);
`ifdef VSI_THIRD_HARM_EN
        chk("steady_a", 32'(d1), 32'd201);
        chk("steady_b", 32'(d2), 32'd27);
        chk("steady_c", 32'(d3), 32'd374);
`else
        chk("steady_a", 32'(d1), 32'd200);
        chk("steady_b", 32'(d2), 32'd26);
        chk("steady_c", 32'(d3), 32'd373);
`endif
        chk("steady_running", 32'(running), 32'd1);

        // Phase wrap: 0x0000 -> 0xFF00 -> 0x0100.
        freq_word = 16'hFF00;
        do_tick(1'b1, 1'b0, 1'b0);
        freq_word = 16'h0200;
        tick_lat();
        do_tick(1'b1, 1'b0, 1'b0);

        // Fault in the same cycle as the internal tick pulse.
        @(negedge clk) pwm_tick = 1'b1;
        @(negedge clk) begin
            pwm_tick = 1'b0;
            fault = 1'b1;
        end
        @(negedge clk);
        chk("fault_ce", 32'(ce), 32'd0);
        chk("fault_d1", 32'(d1), 32'd200);
        chk("fault_d2", 32'(d2), 32'd200);
        chk("fault_d3", 32'(d3), 32'd200);
        chk("fault_faulted", 32'(faulted), 32'd1);
        chk("fault_running", 32'(running), 32'd0);
        m_last = {10'd200, 10'd200, 10'd200};
        repeat (LAT + 4) @(negedge clk);
        chk("fault_hold_d1", 32'(d1), 32'd200);
        chk("fault_hold_d2", 32'(d2), 32'd200);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("fault_tick_d1", 32'(d1), 32'd200);
        fault = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk) fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_ignored", 32'(faulted), 32'd1);
        enable = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk) fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_faulted", 32'(faulted), 32'd0);
        chk("clr_ce", 32'(ce), 32'd0);

        // Ramp to 64 with a moving phase, then stop: 4 ticks down, IDLE on the 5th.
        amp_target = 10'd64;
        freq_word  = 16'h0400;
        enable     = 1'b1;
        m_phase    = 16'd0;
        m_amp      = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) do_tick(1'b1, 1'b0, 1'b0);
        chk("stop_pre_running", 32'(running), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_ce", 32'(ce), 32'd1);
        for (int k = 0; k < 4; k++) do_tick(1'b1, 1'b1, 1'b0);
        chk("stop_ce_at0", 32'(ce), 32'd1);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("stop_idle_ce", 32'(ce), 32'd0);
        chk("stop_idle_d1", 32'(d1), 32'd200);
        m_last = {10'd200, 10'd200, 10'd200};

        // Re-run; enable falls with a tick, then re-enable at 32 and slew down to 8.
        enable  = 1'b1;
        m_phase = 16'd0;
        m_amp   = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b1);
        chk("edge_stop_running", 32'(running), 32'd0);
        do_tick(1'b1, 1'b1, 1'b0);
        amp_target = 10'd8;
        enable = 1'b1;
        @(negedge clk);
        chk("reramp_ce", 32'(ce), 32'd1);
        chk("reramp_running", 32'(running), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            do_tick(1'b1, 1'b0, 1'b0);
            chk("slewdn_running", 32'(running), 32'(k == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vsi_mod_ctrl.md
Name: vsi_mod_ctrl

Overview:
- Modulation controller for the three-phase VSI PWM/dead-time stage.
- Generates the three duty words d1/d2/d3, 120° apart, from a phase accumulator and a sine table.
- Gates the PWM stage through its ce input; runs a start/run/stop/fault state machine with amplitude slew.
- Duty words change only on the PWM period interrupt, so the PWM stage never sees a mid-period change.

Parameters:
- D_MAX, 400: carrier period in clk cycles (10 ns clk, 4 us period); duty clamp ceiling.
- D_MID, 200: zero-voltage duty (50%), must equal D_MAX/2.
- RAMP_STEP, 16: amplitude change per PWM tick (Q10 units).
- PH_W, 16: phase accumulator width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- pwm_tick  in  1  interrupt from PWM stage; its rising edge marks one carrier period.
- enable  in  1  level; 1 = run the bridge, 0 = ramp down and stop.
- fault  in  1  level; 1 = immediate shutdown.
- fault_clr  in  1  single-cycle pulse; acknowledges a latched fault.
- freq_word  in  PH_W  phase increment per tick.
- amp_target  in  10  modulation index, Q10 (1023 ≈ 1.0).
- d1, d2, d3  out  10  duty words for phases a/b/c.
- ce  out  1  enable to PWM stage.
- running  out  1  1 in RUN state.
- faulted  out  1  1 in FAULT state.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE; phase, amp_cur and the tick edge-detect register clear to 0.
  - d1=d2=d3=D_MID; ce=0; running=0; faulted=0.
  - Reset applied mid-operation takes effect the same edge with no ramp-down.
- Tick: registered rising-edge detect of pwm_tick, internal 1-cycle pulse one clk after the edge. Only this pulse advances phase and amplitude.
- States:
  - IDLE: ce=0, duties D_MID. enable=1 -> RAMP with amp_cur=0, phase=0.
  - RAMP: ce=1. Each tick, amp_cur moves toward amp_target by RAMP_STEP, saturating exactly at amp_target. amp_cur==amp_target -> RUN. enable=0 -> STOP.
  - RUN: ce=1, running=1. amp_target changes are slewed by RAMP_STEP per tick. enable=0 -> STOP.
  - STOP: ce=1. amp_cur decrements by RAMP_STEP per tick, saturating at 0. On the tick after amp_cur reaches 0 -> IDLE. enable=1 again -> RAMP without resetting phase or amp_cur.
  - FAULT: ce=0 and duties D_MID on the next clk edge, regardless of tick. faulted=1. Exit to IDLE only on fault_clr=1 with fault=0 and enable=0; otherwise stay.
- fault=1 in any state -> FAULT; it has priority over every other transition.
- Per tick, in RAMP, RUN and STOP:
  - Compute duties from the current phase and amp_cur.
  - Then phase += freq_word, wrapping mod 2^PH_W, and amp_cur steps.
- Duty arithmetic:
  - Angle index θa = phase[PH_W-1:PH_W-8]; θb = θa − 85 (mod 256); θc = θa + 85 (mod 256).
  - sin8(θ) = round-half-away(255·sin(2πθ/256)), signed 9-bit; quarter-wave table of 65 entries mirrored.
  - dx = D_MID + ((amp_cur · sin8(θx) · D_MID) >>> 18), using an arithmetic shift (floor); products are signed, at least 28 bits.
  - Result clamped to [0, D_MAX].
- Pipeline: tick -> angle register -> table register -> product register -> output register.
  - d1..d3 update together, exactly 4 clk after the internal tick pulse; they hold between updates.
  - Latency must stay far below D_MAX.
- Boundaries:
  - Tick coincident with fault: fault wins, no duty update.
  - Tick coincident with enable fall: the transition is taken and the tick is processed in the new state (STOP), so amp_cur steps down.
  - amp_target < amp_cur in RAMP: slew down, then RUN.
  - freq_word=0: duties constant.

Optional Feature:
- Macro: VSI_THIRD_HARM_EN.
- Defined:
  - Adds one pipeline stage (latency 5 clk).
  - Subtracts the common-mode offset (max(ox)+min(ox))/2 (arithmetic shift) from the three offsets ox=dx−D_MID before the clamp.
  - This gives about 15% linear range headroom.
- Undefined: pure sinusoidal duties, latency 4.

Test Plan:
- Reset: rst_n=0 for 3 clk with enable=1 -> d1=d2=d3=200, ce=0, faulted=0; IDLE until rst_n=1.
- Start ramp: enable=1, amp_target=512, RAMP_STEP=16, freq_word=0 -> ce=1 next clk; running=1 after exactly 33 ticks; first-tick duties all 200.
- Steady duties: RUN, amp_cur=1023, phase=0, freq_word=0 -> d1=200, d2=26, d3=373, 4 clk after each tick.
- Phase wrap: phase=0xFF00, freq_word=0x0200 -> next phase 0x0100; θa=0xFF then 0x01; no glitch at wrap.
- Fault: fault=1 mid-RUN, same cycle as a tick -> ce=0 and duties 200 next clk, faulted=1. fault_clr with enable=1 is ignored; with enable=0, fault=0 -> IDLE.
- Stop: enable=0 from RUN at amp_cur=64 -> 4 ticks to 0, IDLE on 5th tick, ce=0; re-asserting enable at amp_cur=32 -> RAMP with phase preserved.
